cfg_frame_loader: RTL and testbench

Configuration-side feeder for the CLB slice mux tree and its sibling config-holding blocks. Accepts a serial bitstream with a valid/ready handshake and assembles it into FRAME_WIDTH-bit frames. Presents each completed frame on a parallel `config_out` bus together with a one-cycle one-hot `cen_out` strobe for the addressed target. The buses connect directly to the targets' `config_in`/`cen` ports. Sits between the fabric-level configuration chain and the per-slice config registers, sequencing NUM_TARGETS frames per load.

---
 rtl/cfg_frame_loader.sv | 156 +++++++++++++++
 tb/tb_cfg_frame_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfg_frame_loader
// Description : Serial configuration loader. Accepts one bit per valid/ready
//               handshake, assembles FRAME_WIDTH-bit frames (first bit in the
//               MSB) and presents each frame on config_out with a one-cycle
//               one-hot cen_out strobe, for NUM_TARGETS targets per sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_frame_loader #(
    parameter int FRAME_WIDTH = 2,
    parameter int NUM_TARGETS = 4
) (
    input  logic                   cclk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cfg_data,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [FRAME_WIDTH-1:0] config_out,
    output logic [NUM_TARGETS-1:0] cen_out,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = $clog2(FRAME_WIDTH + 1);
    localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_TGT = IDX_W'(NUM_TARGETS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]             state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [FRAME_WIDTH-1:0] config_q, config_d;
    logic [NUM_TARGETS-1:0] cen_q,    cen_d;
    logic                   ready_q,  ready_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;

    // Handshake: ready is a flop that is only ever high in SHIFT.
    logic                   w_accept;
    // Frame as it would look if the current bit were appended.
    logic [FRAME_WIDTH-1:0] w_frame;

    assign w_accept = cfg_valid && ready_q;

    // The partial-frame register only exists when a frame spans several bits;
    // it holds the FRAME_WIDTH-1 bits received so far.
    generate
        if (FRAME_WIDTH == 1) begin : g_frame_single
            assign w_frame = cfg_data;
        end else begin : g_frame_multi
            logic [FRAME_WIDTH-2:0] part_q, part_d;

            assign w_frame = {part_q, cfg_data};

            // Shift in the accepted bit; hold otherwise.
            always_comb begin
                part_d = part_q;
                if (w_accept) begin
                    part_d = w_frame[FRAME_WIDTH-2:0];
                end
            end

            // Partial-frame register.
            always_ff @(posedge cclk or negedge rst_n) begin
                if (!rst_n) begin
                    part_q <= '0;
                end else begin
                    part_q <= part_d;
                end
            end
        end
    endgenerate

    // Sequencing: bit counting, frame commit and target stepping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        config_d = config_q;
        cen_d    = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_SHIFT: begin
                if (w_accept) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_d    = '0;
                        config_d = w_frame;
                        cen_d    = NUM_TARGETS'(1) << idx_q;
                        state_d  = S_COMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMMIT: begin
                if (idx_q == LAST_TGT) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_SHIFT);
        busy_d  = (state_d == S_SHIFT) || (state_d == S_COMMIT);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers; reset cuts any strobe short immediately.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            config_q <= '0;
            cen_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            config_q <= config_d;
            cen_q    <= cen_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign config_out = config_q;
    assign cen_out    = cen_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_frame_loader
// Description : Self-checking bench for cfg_frame_loader (default parameters).
//               A sequence-level reference model predicts every output each
//               cycle from the count of accepted bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_frame_loader;

    localparam int FW = 2;
    localparam int NT = 4;

    logic          cclk      = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          cfg_data  = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [FW-1:0] config_out;
    logic [NT-1:0] cen_out;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit          m_active;
    bit          m_commit;
    bit          m_done;
    int          m_acc;
    logic [FW-1:0] m_cfg;
    logic [NT-1:0] m_cen;
    bit          m_bits[$];

    bit          stim_q[$];

    cfg_frame_loader #(
        .FRAME_WIDTH(FW),
        .NUM_TARGETS(NT)
    ) dut (
        .cclk      (cclk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .config_out(config_out),
        .cen_out   (cen_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 cclk = ~cclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("cfg_ready",  32'(cfg_ready),  32'(m_active && !m_commit));
        check("busy",       32'(busy),       32'(m_active));
        check("done",       32'(done),       32'(m_done));
        check("cen_out",    32'(cen_out),    32'(m_cen));
        check("config_out", 32'(config_out), 32'(m_cfg));
    endtask

    task automatic model_reset();
        m_active = 0;
        m_commit = 0;
        m_done   = 0;
        m_acc    = 0;
        m_cfg    = '0;
        m_cen    = '0;
        m_bits.delete();
    endtask

    // Effect of one rising edge at sequence level: after every FW accepted
    // bits a frame is presented for one cycle; after FW*NT bits the load ends.
    task automatic model_edge(input bit v, input bit d, input bit s);
        int val;
        if (m_commit) begin
            m_commit = 0;
            m_cen    = '0;
            if (m_acc == FW * NT) begin
                m_active = 0;
                m_done   = 1;
            end
        end else if (m_active) begin
            if (v) begin
                m_bits.push_back(d);
                m_acc++;
                if (m_acc % FW == 0) begin
                    val = 0;
                    for (int k = 0; k < FW; k++) begin
                        val = val * 2 + int'(m_bits[m_acc - FW + k]);
                    end
                    m_cfg    = FW'(val);
                    m_cen    = NT'(1) << (m_acc / FW - 1);
                    m_commit = 1;
                end
            end
        end else if (s) begin
            m_active = 1;
            m_done   = 0;
            m_acc    = 0;
            m_bits.delete();
        end
    endtask

    // Called at a falling edge: check, drive, advance the model, wait one cycle.
    task automatic cycle(input bit v, input bit d, input bit s);
        check_outputs();
        start     = s;
        cfg_valid = v;
        cfg_data  = d;
        model_edge(v, d, s);
        @(negedge cclk);
    endtask

    task automatic fill_fixed();
        stim_q = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    endtask

    task automatic fill_random();
        stim_q.delete();
        for (int i = 0; i < FW * NT; i++) begin
            stim_q.push_back(bit'($urandom_range(0, 1)));
        end
    endtask

    // Reset asserted between edges while a strobe is high.
    task automatic do_abort();
        check("cen_before_abort", 32'(cen_out), 32'(4'b0010));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_cen",    32'(cen_out),    32'h0);
        check("abort_config", 32'(config_out), 32'h0);
        check("abort_ready",  32'(cfg_ready),  32'h0);
        check("abort_busy",   32'(busy),       32'h0);
        model_reset();
        start     = 1'b0;
        cfg_valid = 1'b0;
        @(negedge cclk);
        rst_n = 1'b1;
        @(negedge cclk);
    endtask

    // One load sequence from IDLE/DONE, streaming stim_q.
    task automatic run_load(input int stall_at, input int stall_len, input bit rand_valid,
                            input int busy_start_at, input bit abort_on_t1, input int exp_lat);
        int p          = 0;
        int n          = 0;
        int stalled    = 0;
        int first_done = -1;
        bit v, d, s;
        cycle(1'b0, bit'($urandom_range(0, 1)), 1'b1);
        while (!m_done && n < 200) begin
            s = (n == busy_start_at);
            if (p == stall_at && stalled < stall_len) begin
                v = 0;
                stalled++;
            end else if (rand_valid) begin
                v = ($urandom_range(0, 2) != 0);
            end else begin
                v = 1;
            end
            d = (v && p < stim_q.size()) ? stim_q[p] : bit'($urandom_range(0, 1));
            if (v && m_active && !m_commit) p++;
            cycle(v, d, s);
            n++;
            if (done === 1'b1 && first_done < 0) first_done = n;
            if (abort_on_t1 && m_cen == NT'(2)) begin
                do_abort();
                return;
            end
        end
        check_outputs();
        check("done_seen", 32'(first_done >= 0), 32'h1);
        if (exp_lat >= 0) check("done_latency", 32'(first_done), 32'(exp_lat));
    endtask

    initial begin
        model_reset();
        // Reset defaults while clock toggles.
        repeat (3) @(negedge cclk);
        check("rst_ready",  32'(cfg_ready),  32'h0);
        check("rst_cen",    32'(cen_out),    32'h0);
        check("rst_config", 32'(config_out), 32'h0);
        check("rst_busy",   32'(busy),       32'h0);
        check("rst_done",   32'(done),       32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0);

        // Full load, valid held high (also covers backpressure during COMMIT).
        fill_fixed();
        run_load(-1, 0, 1'b0, -1, 1'b0, 12);
        // Restart from DONE with a 3-cycle stall inside frame 1.
        run_load(3, 3, 1'b0, -1, 1'b0, 15);
        // Start pulsed mid-frame 2 must be ignored.
        run_load(-1, 0, 1'b0, 4, 1'b0, 12);
        // Asynchronous reset while target 1 is being strobed.
        run_load(-1, 0, 1'b0, -1, 1'b1, -1);
        // Next load after reset starts at target 0.
        run_load(-1, 0, 1'b0, -1, 1'b0, 12);

        // Randomized streams with random valid gaps.
        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_load(-1, 0, 1'b1, int'($urandom_range(0, 20)), 1'b0, -1);
            for (int i = 0; i < 3; i++) cycle(1'b0, bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
